// File: rtl/execute_stage_p.sv
// Execute stage: ALU, optional shift-add multiplier, registered EX/MEM slot
// with valid/ready handshake, and the architectural {C,N,Z} flag register.
module execute_stage_p #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned MUL_EN = 1,
    parameter int unsigned CNT_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] read_data1,
    input  logic [WIDTH-1:0] read_data2,
    input  logic [2:0]       func,
    input  logic             mul,
    input  logic             flag_we,
    input  logic             setc,
    input  logic             clrc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic [2:0]       flags,
    output logic             busy
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    localparam logic [2:0] FN_ADD = 3'd0;
    localparam logic [2:0] FN_SUB = 3'd1;
    localparam logic [2:0] FN_AND = 3'd2;
    localparam logic [2:0] FN_OR  = 3'd3;
    localparam logic [2:0] FN_MOV = 3'd4;
    localparam logic [2:0] FN_NOT = 3'd5;
    localparam logic [2:0] FN_SHL = 3'd6;
    localparam logic [2:0] FN_SHR = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    // Multiplier datapath
    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]    acc;
    logic [CNT_W-1:0] cnt;
    logic             mulFlagWe;

    // ALU outputs
    logic [WIDTH-1:0] aluRes;
    logic             aluCarry;
    logic             aluCarryDef;
    logic [WIDTH:0]   addWide;
    logic [WIDTH:0]   shlWide;
    logic [WIDTH:0]   shrWide;
    logic [3:0]       shAmt;

    // Handshake / control decode
    logic wantMul;
    logic slotFree;
    logic accept;
    logic isCarryOp;
    logic startMul;
    logic loadAlu;
    logic loadMul;

    // Combinational ALU; carry is only meaningful where aluCarryDef is set
    always_comb begin
        aluRes      = '0;
        aluCarry    = 1'b0;
        aluCarryDef = 1'b0;
        shAmt       = read_data2[3:0];
        addWide     = {1'b0, read_data1} + {1'b0, read_data2};
        // Extra bit above/below the operand captures the last bit shifted out
        shlWide     = {1'b0, read_data1} << shAmt;
        shrWide     = {read_data1, 1'b0} >> shAmt;
        case (func)
            FN_ADD: begin
                aluRes      = addWide[WIDTH-1:0];
                aluCarry    = addWide[WIDTH];
                aluCarryDef = 1'b1;
            end
            FN_SUB: begin
                aluRes      = read_data1 - read_data2;
                aluCarry    = (read_data1 < read_data2);
                aluCarryDef = 1'b1;
            end
            FN_AND: aluRes = read_data1 & read_data2;
            FN_OR:  aluRes = read_data1 | read_data2;
            FN_MOV: aluRes = read_data2;
            FN_NOT: aluRes = ~read_data1;
            FN_SHL: begin
                aluRes      = shlWide[WIDTH-1:0];
                aluCarry    = shlWide[WIDTH];
                aluCarryDef = (shAmt != 4'd0);
            end
            FN_SHR: begin
                aluRes      = shrWide[WIDTH:1];
                aluCarry    = shrWide[0];
                aluCarryDef = (shAmt != 4'd0);
            end
            default: aluRes = '0;
        endcase
    end

    // Handshake and load decode; a carry-only bundle never produces a result
    always_comb begin
        wantMul   = (MUL_EN != 0) ? mul : 1'b0;
        slotFree  = !out_valid || out_ready;
        in_ready  = (state == IDLE) && slotFree && !flush;
        accept    = in_valid && in_ready;
        isCarryOp = setc || clrc;
        startMul  = accept && !isCarryOp && wantMul;
        loadAlu   = accept && !isCarryOp && !wantMul;
        loadMul   = (state == DONE) && slotFree && !flush;
    end

    // Control FSM and iterative shift-add multiplier
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            mulFlagWe <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (startMul) begin
                        state     <= MUL;
                        busy      <= 1'b1;
                        mcand     <= PW'(read_data1);
                        mplier    <= read_data2;
                        acc       <= '0;
                        cnt       <= '0;
                        mulFlagWe <= flag_we;
                    end
                end
                MUL: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST_STEP) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    if (slotFree) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // EX/MEM output slot: load a new result, hold under back-pressure, else drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            alu_result <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (loadAlu) begin
            out_valid  <= 1'b1;
            alu_result <= aluRes;
        end else if (loadMul) begin
            out_valid  <= 1'b1;
            alu_result <= acc[WIDTH-1:0];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Flag register {C,N,Z}: written only alongside a slot load, or by setc/clrc
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags <= 3'b000;
        end else if (accept && isCarryOp) begin
            flags[2] <= setc;
        end else if (loadAlu && flag_we) begin
            flags[0] <= (aluRes == '0);
            flags[1] <= aluRes[WIDTH-1];
            if (aluCarryDef) begin
                flags[2] <= aluCarry;
            end
        end else if (loadMul && mulFlagWe) begin
            flags <= {(acc[PW-1:WIDTH] != '0), acc[WIDTH-1], (acc[WIDTH-1:0] == '0)};
        end
    end

endmodule
